// File: rtl/text_console_ctrl.sv
// Write-side sequencer for the 50x30 character video memory: cursor tracking, control codes, row/screen blanking.
// Define CONSOLE_TAB_EN to expand 0x09 into blank cells up to the next multiple-of-8 column.
module text_console_ctrl #(
    parameter int         COLS   = 50,
    parameter int         ROWS   = 30,
    parameter int         ADDR_W = 11,
    parameter logic [7:0] BLANK  = 8'h20
) (
    input  logic              CLK_CPU,
    input  logic              resetn,
    input  logic              char_valid,
    input  logic [7:0]        char_data,
    output logic              char_ready,
    input  logic              clear_req,
    output logic              busy,
    output logic              video_write_enable,
    output logic [7:0]        video_write_data,
    output logic [ADDR_W-1:0] video_write_addr,
    output logic [5:0]        cursor_col,
    output logic [4:0]        cursor_row
);

    // state   | meaning
    // CLR_ALL | blank every cell 0..COLS*ROWS-1, then home the cursor
    // IDLE    | accept characters / control codes, or start a pending clear
    // CLR_ROW | blank the row the cursor just moved onto
    // TAB     | blank cells and step right until col%8==0 (CONSOLE_TAB_EN only)
`ifdef CONSOLE_TAB_EN
    typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_ROW, TAB} state_t;
`else
    typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_ROW} state_t;
`endif

    localparam logic [ADDR_W-1:0] CELLS_LAST = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST_N = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(COLS);
    localparam logic [5:0]        COL_LAST   = 6'(COLS - 1);
    localparam logic [4:0]        ROW_LAST   = 5'(ROWS - 1);

    state_t              state_q, state_d;
    logic [5:0]          col_q, col_d;
    logic [4:0]          row_q, row_d;
    logic [ADDR_W-1:0]   row_base_q, row_base_d;
    logic                clr_pend_q, clr_pend_d;
    logic [ADDR_W-1:0]   sweep_addr_q, sweep_addr_d;
    logic [ADDR_W-1:0]   sweep_left_q, sweep_left_d;
    logic                we_q, we_d;
    logic [7:0]          wdata_q, wdata_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [ADDR_W-1:0]   cell_addr;
    logic                adv_row;

    assign cell_addr  = row_base_q + ADDR_W'(col_q);
    assign char_ready = (state_q == IDLE) && !clear_req && !clr_pend_q;
    assign busy       = (state_q != IDLE);

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        row_base_d   = row_base_q;
        clr_pend_d   = clr_pend_q;
        sweep_addr_d = sweep_addr_q;
        sweep_left_d = sweep_left_q;
        we_d         = 1'b0;
        wdata_d      = wdata_q;
        waddr_d      = waddr_q;
        adv_row      = 1'b0;

        if (clear_req && (state_q != IDLE)) clr_pend_d = 1'b1;

        case (state_q)
            CLR_ALL: begin
                we_d         = 1'b1;
                wdata_d      = BLANK;
                waddr_d      = sweep_addr_q;
                sweep_addr_d = sweep_addr_q + ADDR_W'(1);
                sweep_left_d = sweep_left_q - ADDR_W'(1);
                if (sweep_left_q == '0) begin
                    state_d    = IDLE;
                    col_d      = '0;
                    row_d      = '0;
                    row_base_d = '0;
                    clr_pend_d = 1'b0;
                end
            end
            IDLE: begin
                if (clear_req || clr_pend_q) begin
                    state_d      = CLR_ALL;
                    clr_pend_d   = 1'b0;
                    sweep_addr_d = '0;
                    sweep_left_d = CELLS_LAST;
                end else if (char_valid) begin
                    if (char_data >= 8'h20 && char_data <= 8'h7E) begin
                        we_d    = 1'b1;
                        wdata_d = char_data;
                        waddr_d = cell_addr;
                        if (col_q == COL_LAST) begin
                            col_d   = '0;
                            adv_row = 1'b1;
                        end else begin
                            col_d = col_q + 6'd1;
                        end
                    end else if (char_data == 8'h0A) begin
                        col_d   = '0;
                        adv_row = 1'b1;
                    end else if (char_data == 8'h0D) begin
                        col_d = '0;
                    end else if (char_data == 8'h08) begin
                        if (col_q != '0) begin
                            col_d   = col_q - 6'd1;
                            we_d    = 1'b1;
                            wdata_d = BLANK;
                            waddr_d = cell_addr - ADDR_W'(1);
                        end
`ifdef CONSOLE_TAB_EN
                    end else if (char_data == 8'h09) begin
                        state_d = TAB;
`endif
                    end
                end
            end
            CLR_ROW: begin
                we_d         = 1'b1;
                wdata_d      = BLANK;
                waddr_d      = sweep_addr_q;
                sweep_addr_d = sweep_addr_q + ADDR_W'(1);
                sweep_left_d = sweep_left_q - ADDR_W'(1);
                if (sweep_left_q == '0) state_d = IDLE;
            end
`ifdef CONSOLE_TAB_EN
            TAB: begin
                we_d    = 1'b1;
                wdata_d = BLANK;
                waddr_d = cell_addr;
                if (col_q == COL_LAST) begin
                    col_d   = '0;
                    adv_row = 1'b1;
                end else begin
                    col_d = col_q + 6'd1;
                    if (col_q[2:0] == 3'd7) state_d = IDLE;
                end
            end
`endif
            default: state_d = CLR_ALL;
        endcase

        // Row wrap returns to the top without scrolling; the new row is always blanked.
        if (adv_row) begin
            if (row_q == ROW_LAST) begin
                row_d      = '0;
                row_base_d = '0;
            end else begin
                row_d      = row_q + 5'd1;
                row_base_d = row_base_q + STRIDE;
            end
            state_d      = CLR_ROW;
            sweep_addr_d = row_base_d;
            sweep_left_d = ROW_LAST_N;
        end
    end

    always_ff @(posedge CLK_CPU or negedge resetn) begin
        if (!resetn) begin
            state_q      <= CLR_ALL;
            col_q        <= '0;
            row_q        <= '0;
            row_base_q   <= '0;
            clr_pend_q   <= 1'b0;
            sweep_addr_q <= '0;
            sweep_left_q <= CELLS_LAST;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            waddr_q      <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            row_base_q   <= row_base_d;
            clr_pend_q   <= clr_pend_d;
            sweep_addr_q <= sweep_addr_d;
            sweep_left_q <= sweep_left_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            waddr_q      <= waddr_d;
        end
    end

    assign video_write_enable = we_q;
    assign video_write_data   = wdata_q;
    assign video_write_addr   = waddr_q;
    assign cursor_col         = col_q;
    assign cursor_row         = row_q;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed bench for text_console_ctrl: vector table for single-cycle codes plus sweep/wrap/clear/reset sequences.
module tb_text_console_ctrl;

    logic        CLK_CPU = 1'b0;
    logic        resetn = 1'b0;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic        clear_req = 1'b0;
    logic        char_ready;
    logic        busy;
    logic        video_write_enable;
    logic [7:0]  video_write_data;
    logic [10:0] video_write_addr;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;

    int n_checks = 0;
    int n_pass = 0;

    text_console_ctrl dut (
        .CLK_CPU            (CLK_CPU),
        .resetn             (resetn),
        .char_valid         (char_valid),
        .char_data          (char_data),
        .char_ready         (char_ready),
        .clear_req          (clear_req),
        .busy               (busy),
        .video_write_enable (video_write_enable),
        .video_write_data   (video_write_data),
        .video_write_addr   (video_write_addr),
        .cursor_col         (cursor_col),
        .cursor_row         (cursor_row)
    );

    always #5 CLK_CPU = ~CLK_CPU;

    typedef struct {
        logic [7:0] c;
        int         we;
        int         data;
        int         addr;
        int         col;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Called at a negedge in IDLE; returns at the next negedge (strobe of this char visible).
    task automatic accept(input logic [7:0] c);
        chk("ready_before_accept", int'(char_ready), 1);
        char_valid = 1'b1;
        char_data  = c;
        @(negedge CLK_CPU);
        char_valid = 1'b0;
    endtask

    task automatic expect_sweep(input string name, input int base, input int len, input int max_wait);
        int w = 0;
        int bad = 0;
        @(negedge CLK_CPU);
        while (video_write_enable !== 1'b1 && w < max_wait) begin
            @(negedge CLK_CPU);
            w++;
        end
        chk({name, "_start"}, int'(video_write_enable), 1);
        if (video_write_enable === 1'b1) begin
            for (int i = 0; i < len; i++) begin
                if (i > 0) @(negedge CLK_CPU);
                if (video_write_enable !== 1'b1 || int'(video_write_addr) != base + i ||
                    video_write_data !== 8'h20) bad++;
                if (i < len - 1 && (busy !== 1'b1 || char_ready !== 1'b0)) bad++;
            end
            chk({name, "_cells"}, bad, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Starting at row 0, col 2 (after 'A','B').
        vecs[0]  = '{c: 8'h43, we: 1, data: 'h43, addr: 2, col: 3};
        vecs[1]  = '{c: 8'h0D, we: 0, data: 0,    addr: 0, col: 0};
        vecs[2]  = '{c: 8'h07, we: 0, data: 0,    addr: 0, col: 0};
        vecs[3]  = '{c: 8'h08, we: 0, data: 0,    addr: 0, col: 0};
        vecs[4]  = '{c: 8'h78, we: 1, data: 'h78, addr: 0, col: 1};
        vecs[5]  = '{c: 8'h08, we: 1, data: 'h20, addr: 0, col: 0};
        vecs[6]  = '{c: 8'h7E, we: 1, data: 'h7E, addr: 0, col: 1};
        vecs[7]  = '{c: 8'h7F, we: 0, data: 0,    addr: 0, col: 1};
        vecs[8]  = '{c: 8'h1F, we: 0, data: 0,    addr: 0, col: 1};
        vecs[9]  = '{c: 8'h20, we: 1, data: 'h20, addr: 1, col: 2};
        vecs[10] = '{c: 8'h80, we: 0, data: 0,    addr: 0, col: 2};
        vecs[11] = '{c: 8'hFF, we: 0, data: 0,    addr: 0, col: 2};
        vecs[12] = '{c: 8'h0D, we: 0, data: 0,    addr: 0, col: 0};

        // Reset state
        repeat (3) @(negedge CLK_CPU);
        chk("rst_we", int'(video_write_enable), 0);
        chk("rst_data", int'(video_write_data), 0);
        chk("rst_addr", int'(video_write_addr), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_ready", int'(char_ready), 0);
        chk("rst_col", int'(cursor_col), 0);
        chk("rst_row", int'(cursor_row), 0);
        resetn = 1'b1;

        // Initial full-screen clear
        expect_sweep("init_clr", 0, 1500, 4);
        chk("init_busy_end", int'(busy), 0);
        chk("init_ready_end", int'(char_ready), 1);
        chk("init_col", int'(cursor_col), 0);
        chk("init_row", int'(cursor_row), 0);
        @(negedge CLK_CPU);
        chk("init_no_extra", int'(video_write_enable), 0);

        // Back-to-back 'A','B'
        accept(8'h41);
        chk("A_we", int'(video_write_enable), 1);
        chk("A_data", int'(video_write_data), 'h41);
        chk("A_addr", int'(video_write_addr), 0);
        accept(8'h42);
        chk("B_we", int'(video_write_enable), 1);
        chk("B_data", int'(video_write_data), 'h42);
        chk("B_addr", int'(video_write_addr), 1);
        chk("B_col", int'(cursor_col), 2);
        chk("B_ready", int'(char_ready), 1);

        // Single-cycle code table
        foreach (vecs[i]) begin
            accept(vecs[i].c);
            chk($sformatf("vec%0d_we", i), int'(video_write_enable), vecs[i].we);
            if (vecs[i].we == 1) begin
                chk($sformatf("vec%0d_data", i), int'(video_write_data), vecs[i].data);
                chk($sformatf("vec%0d_addr", i), int'(video_write_addr), vecs[i].addr);
            end
            chk($sformatf("vec%0d_col", i), int'(cursor_col), vecs[i].col);
            chk($sformatf("vec%0d_row", i), int'(cursor_row), 0);
        end

        // Walk down to row 29 with LFs, each blanking its new row
        for (int r = 1; r < 30; r++) begin
            accept(8'h0A);
            chk("lf_nowrite", int'(video_write_enable), 0);
            expect_sweep("lf_row", r * 50, 50, 2);
        end
        chk("lf_row29", int'(cursor_row), 29);
        for (int k = 0; k < 49; k++) accept(8'h61);
        chk("col49", int'(cursor_col), 49);

        // Last cell of the screen, wrap to row 0
        accept(8'h5A);
        chk("wrap_we", int'(video_write_enable), 1);
        chk("wrap_data", int'(video_write_data), 'h5A);
        chk("wrap_addr", int'(video_write_addr), 1499);
        chk("wrap_ready_low", int'(char_ready), 0);
        expect_sweep("wrap_row0", 0, 50, 2);
        chk("wrap_col", int'(cursor_col), 0);
        chk("wrap_row", int'(cursor_row), 0);
        chk("wrap_ready_back", int'(char_ready), 1);

        // Row 2 col 0: BS is a no-op, LF blanks row 3
        accept(8'h0A);
        expect_sweep("to_row1", 50, 50, 2);
        accept(8'h0A);
        expect_sweep("to_row2", 100, 50, 2);
        accept(8'h08);
        chk("bs0_we", int'(video_write_enable), 0);
        chk("bs0_col", int'(cursor_col), 0);
        chk("bs0_row", int'(cursor_row), 2);
        accept(8'h0A);
        chk("lf3_we", int'(video_write_enable), 0);
        expect_sweep("lf3_row", 150, 50, 2);
        chk("lf3_row", int'(cursor_row), 3);
        chk("lf3_col", int'(cursor_col), 0);

        // clear_req wins over a simultaneous char
        accept(8'h51);
        clear_req  = 1'b1;
        char_valid = 1'b1;
        char_data  = 8'h41;
        #1;
        chk("clr_ready_low", int'(char_ready), 0);
        @(negedge CLK_CPU);
        clear_req  = 1'b0;
        char_valid = 1'b0;
        chk("clr_nowrite", int'(video_write_enable), 0);
        chk("clr_col_kept", int'(cursor_col), 1);
        chk("clr_busy", int'(busy), 1);
        expect_sweep("clr_all", 0, 1500, 4);
        chk("clr_col", int'(cursor_col), 0);
        chk("clr_row", int'(cursor_row), 0);

        // clear_req during CLR_ROW is held pending, then serviced
        accept(8'h0A);
        clear_req = 1'b1;
        fork
            begin
                @(negedge CLK_CPU);
                clear_req = 1'b0;
            end
        join_none
        expect_sweep("pend_row", 50, 50, 2);
        chk("pend_ready_low", int'(char_ready), 0);
        chk("pend_row_val", int'(cursor_row), 1);
        fork
            begin
                repeat (10) @(negedge CLK_CPU);
                clear_req = 1'b1;
                @(negedge CLK_CPU);
                clear_req = 1'b0;
            end
        join_none
        expect_sweep("pend_clr", 0, 1500, 3);
        chk("pend_col", int'(cursor_col), 0);
        chk("pend_row", int'(cursor_row), 0);
        chk("absorb_ready", int'(char_ready), 1);
        repeat (3) @(negedge CLK_CPU);
        chk("absorb_no_sweep", int'(video_write_enable), 0);
        chk("absorb_idle", int'(busy), 0);

        // TAB at col 5
        for (int k = 0; k < 5; k++) accept(8'h61);
        accept(8'h09);
        chk("tab_entry_we", int'(video_write_enable), 0);
`ifdef CONSOLE_TAB_EN
        chk("tab_busy", int'(busy), 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK_CPU);
            chk($sformatf("tab_we%0d", k), int'(video_write_enable), 1);
            chk($sformatf("tab_addr%0d", k), int'(video_write_addr), 5 + k);
            chk($sformatf("tab_data%0d", k), int'(video_write_data), 'h20);
        end
        chk("tab_col", int'(cursor_col), 8);
        chk("tab_idle", int'(busy), 0);
        @(negedge CLK_CPU);
        chk("tab_stop", int'(video_write_enable), 0);
        for (int k = 0; k < 40; k++) accept(8'h62);
        accept(8'h09);
        @(negedge CLK_CPU);
        chk("tabw_addr48", int'(video_write_addr), 48);
        @(negedge CLK_CPU);
        chk("tabw_addr49", int'(video_write_addr), 49);
        expect_sweep("tabw_row", 50, 50, 2);
        chk("tabw_row", int'(cursor_row), 1);
        chk("tabw_col", int'(cursor_col), 0);
`else
        chk("tab_col", int'(cursor_col), 5);
        chk("tab_idle", int'(busy), 0);
`endif

        // Reset in the middle of a row sweep restarts the full clear
        accept(8'h0A);
        repeat (10) @(negedge CLK_CPU);
        resetn = 1'b0;
        #1;
        chk("mid_rst_we", int'(video_write_enable), 0);
        chk("mid_rst_addr", int'(video_write_addr), 0);
        chk("mid_rst_busy", int'(busy), 1);
        chk("mid_rst_row", int'(cursor_row), 0);
        @(negedge CLK_CPU);
        resetn = 1'b1;
        expect_sweep("mid_rst_clr", 0, 1500, 4);
        chk("mid_rst_ready", int'(char_ready), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
